// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bus carried by pipe_stage_reg: upstream in_* fields and the registered out_* fields.
// Handshake: in_valid qualifies in_data/in_pc; out_valid qualifies out_data/out_pc. No back-pressure; stalls come from the stop vector.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 38,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;

    // Upstream stage / bench side: produces in_*, observes out_*.
    modport master (
        output in_valid, in_data, in_pc,
        input  out_valid, out_data, out_pc
    );

    // Pipeline register side: consumes in_*, produces out_*.
    modport slave (
        input  in_valid, in_data, in_pc,
        output out_valid, out_data, out_pc
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register with stall hold, bubble insertion, flush,
// and saturating stall/bubble counters. All outputs are registered.
module pipe_stage_reg #(
    parameter int                 DATA_W          = 38,
    parameter int                 PC_W            = 32,
    parameter int                 STOP_W          = 6,
    parameter int                 STAGE_IDX       = 4,
    parameter bit                 CLEAR_ON_BUBBLE = 1'b1,
    parameter logic [PC_W-1:0]    RESET_PC        = '0,
    parameter int                 CNT_W           = 16
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    pipe_stage_reg_if.slave      bus,
    input  logic [STOP_W-1:0]    stop,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    if (STAGE_IDX + 1 >= STOP_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX+1 must be below STOP_W");
    end

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_HOLD    = 3'd3,
        ACT_ADVANCE = 3'd4
    } action_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic    up;
    logic    dn;
    action_t action;
    logic    kill;
    logic    zero_fill;
    logic    unused_stop_bits;

    assign up = stop[STAGE_IDX];
    assign dn = stop[STAGE_IDX+1];

    // Only up/dn steer this stage; the remaining stall bits belong to other stages.
    assign unused_stop_bits = ^stop;

    // Action is a pure function of the current inputs, in strict priority order.
    // dn=1 with up=0 never comes from the stall controller and is taken as ADVANCE.
    always_comb begin
        action = ACT_ADVANCE;
        if (cpu_rst) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (up && !dn) begin
            action = ACT_BUBBLE;
        end else if (up && dn) begin
            action = ACT_HOLD;
        end
    end

    assign kill      = (action == ACT_FLUSH) || (action == ACT_BUBBLE);
    assign zero_fill = kill && CLEAR_ON_BUBBLE;

    always_ff @(posedge cpu_clk) begin
        case (action)
            ACT_RESET: begin
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
                bus.out_pc    <= RESET_PC;
            end
            ACT_FLUSH, ACT_BUBBLE: begin
                bus.out_valid <= 1'b0;
                // Low-toggle mode keeps payload/PC wires quiet across bubbles.
                if (zero_fill) begin
                    bus.out_data <= '0;
                    bus.out_pc   <= RESET_PC;
                end
            end
            ACT_HOLD: begin
                bus.out_valid <= bus.out_valid;
                bus.out_data  <= bus.out_data;
                bus.out_pc    <= bus.out_pc;
            end
            default: begin
                bus.out_valid <= bus.in_valid;
                bus.out_data  <= bus.in_data;
                bus.out_pc    <= bus.in_pc;
            end
        endcase
    end

    // Counters saturate; a clear wins over a same-cycle increment.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if ((action == ACT_HOLD) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (kill && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table-driven vectors over three default-shaped instances
// (clear mode, low-toggle mode, 4-bit counters) plus hand sequences for saturation and a wide/STAGE_IDX=0 instance.
module tb_pipe_stage_reg;

    localparam logic [31:0] R = 32'hBFC0_0000;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    always #5 cpu_clk = ~cpu_clk;

    logic [5:0]  stop    = '0;
    logic        flush   = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [5:0]  stop3   = '0;

    logic [15:0] stall0, bubble0, stall1, bubble1, stall3, bubble3;
    logic [3:0]  stall2, bubble2;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg_if #(.DATA_W(38), .PC_W(32)) bus0 ();
    pipe_stage_reg_if #(.DATA_W(38), .PC_W(32)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(38), .PC_W(32)) bus2 ();
    pipe_stage_reg_if #(.DATA_W(70), .PC_W(32)) bus3 ();

    pipe_stage_reg #(.CLEAR_ON_BUBBLE(1'b1), .RESET_PC(R)) u0 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus0), .stop(stop), .flush(flush),
        .cnt_clr(cnt_clr), .stall_cnt(stall0), .bubble_cnt(bubble0));
    pipe_stage_reg #(.CLEAR_ON_BUBBLE(1'b0), .RESET_PC(R)) u1 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus1), .stop(stop), .flush(flush),
        .cnt_clr(cnt_clr), .stall_cnt(stall1), .bubble_cnt(bubble1));
    pipe_stage_reg #(.CLEAR_ON_BUBBLE(1'b1), .RESET_PC(R), .CNT_W(4)) u2 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus2), .stop(stop), .flush(flush),
        .cnt_clr(cnt_clr), .stall_cnt(stall2), .bubble_cnt(bubble2));
    pipe_stage_reg #(.DATA_W(70), .STAGE_IDX(0), .CLEAR_ON_BUBBLE(1'b1)) u3 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus3), .stop(stop3), .flush(1'b0),
        .cnt_clr(1'b0), .stall_cnt(stall3), .bubble_cnt(bubble3));

    typedef struct {
        logic        rst;
        logic        iv;
        logic [37:0] d;
        logic [31:0] pc;
        logic [5:0]  st;
        logic        fl;
        logic        clr;
        logic        ev;
        logic [37:0] ed0;
        logic [37:0] ed1;
        logic [31:0] ep0;
        logic [31:0] ep1;
        logic [15:0] es;
        logic [15:0] eb;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rst, logic iv, logic [37:0] d, logic [31:0] pc, logic [5:0] st,
                                logic fl, logic clr, logic ev, logic [37:0] ed0, logic [37:0] ed1,
                                logic [31:0] ep0, logic [31:0] ep1, logic [15:0] es, logic [15:0] eb);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.pc = pc; v.st = st; v.fl = fl; v.clr = clr;
        v.ev = ev; v.ed0 = ed0; v.ed1 = ed1; v.ep0 = ep0; v.ep1 = ep1; v.es = es; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_all(input logic iv, input logic [37:0] d, input logic [31:0] pc);
        bus0.in_valid = iv; bus0.in_data = d; bus0.in_pc = pc;
        bus1.in_valid = iv; bus1.in_data = d; bus1.in_pc = pc;
        bus2.in_valid = iv; bus2.in_data = d; bus2.in_pc = pc;
    endtask

    task automatic tick();
        if (stop[5] && !stop[4] && !cpu_rst)
            $display("protocol warning: downstream stalled while upstream runs at %0t", $time);
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        logic [69:0] d1;
        logic [69:0] d2;

        vecs[0]  = mk(1, 1, 'h2A, 'h500, 6'b000000, 0, 0,  0, 0, 0, R, R, 0, 0);
        vecs[1]  = mk(1, 1, 'h2A, 'h500, 6'b000000, 0, 0,  0, 0, 0, R, R, 0, 0);
        vecs[2]  = mk(0, 1, 1, 'h100, 6'b000000, 0, 0,  1, 1, 1, 'h100, 'h100, 0, 0);
        vecs[3]  = mk(0, 1, 2, 'h104, 6'b000000, 0, 0,  1, 2, 2, 'h104, 'h104, 0, 0);
        vecs[4]  = mk(0, 1, 3, 'h108, 6'b000000, 0, 0,  1, 3, 3, 'h108, 'h108, 0, 0);
        vecs[5]  = mk(0, 1, 4, 'h10C, 6'b110000, 0, 0,  1, 3, 3, 'h108, 'h108, 1, 0);
        vecs[6]  = mk(0, 1, 4, 'h10C, 6'b110000, 0, 0,  1, 3, 3, 'h108, 'h108, 2, 0);
        vecs[7]  = mk(0, 1, 4, 'h10C, 6'b110000, 0, 0,  1, 3, 3, 'h108, 'h108, 3, 0);
        vecs[8]  = mk(0, 1, 4, 'h10C, 6'b010000, 0, 0,  0, 0, 3, R, 'h108, 3, 1);
        vecs[9]  = mk(0, 1, 5, 'h110, 6'b000000, 0, 0,  1, 5, 5, 'h110, 'h110, 3, 1);
        vecs[10] = mk(0, 1, 9, 'h200, 6'b110000, 1, 0,  0, 0, 5, R, 'h110, 3, 2);
        vecs[11] = mk(0, 0, 6, 'h114, 6'b000000, 0, 0,  0, 6, 6, 'h114, 'h114, 3, 2);
        vecs[12] = mk(0, 1, 7, 'h300, 6'b010000, 0, 0,  0, 0, 6, R, 'h114, 3, 3);
        vecs[13] = mk(0, 1, 7, 'h118, 6'b000001, 0, 0,  1, 7, 7, 'h118, 'h118, 3, 3);
        vecs[14] = mk(0, 1, 8, 'h11C, 6'b100000, 0, 0,  1, 8, 8, 'h11C, 'h11C, 3, 3);
        vecs[15] = mk(0, 1, 'hA, 'h400, 6'b110000, 0, 1,  1, 8, 8, 'h11C, 'h11C, 0, 0);
        vecs[16] = mk(0, 1, 'hA, 'h400, 6'b110000, 0, 0,  1, 8, 8, 'h11C, 'h11C, 1, 0);
        vecs[17] = mk(0, 1, 'hA, 'h400, 6'b010000, 0, 1,  0, 0, 8, R, 'h11C, 0, 0);
        vecs[18] = mk(1, 1, 'hB, 'h500, 6'b110000, 1, 0,  0, 0, 0, R, R, 0, 0);
        vecs[19] = mk(0, 1, 9, 'h120, 6'b000000, 0, 0,  1, 9, 9, 'h120, 'h120, 0, 0);

        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_pc = '0;
        drive_all(1'b0, '0, '0);
        #2;

        for (int i = 0; i < NV; i++) begin
            cpu_rst = vecs[i].rst; stop = vecs[i].st; flush = vecs[i].fl; cnt_clr = vecs[i].clr;
            drive_all(vecs[i].iv, vecs[i].d, vecs[i].pc);
            tick();
            check($sformatf("v%0d clr.valid", i), 70'(bus0.out_valid), 70'(vecs[i].ev));
            check($sformatf("v%0d clr.data", i), 70'(bus0.out_data), 70'(vecs[i].ed0));
            check($sformatf("v%0d clr.pc", i), 70'(bus0.out_pc), 70'(vecs[i].ep0));
            check($sformatf("v%0d hold.valid", i), 70'(bus1.out_valid), 70'(vecs[i].ev));
            check($sformatf("v%0d hold.data", i), 70'(bus1.out_data), 70'(vecs[i].ed1));
            check($sformatf("v%0d hold.pc", i), 70'(bus1.out_pc), 70'(vecs[i].ep1));
            check($sformatf("v%0d stall_cnt", i), 70'(stall0), 70'(vecs[i].es));
            check($sformatf("v%0d bubble_cnt", i), 70'(bubble0), 70'(vecs[i].eb));
            check($sformatf("v%0d hold.stall_cnt", i), 70'(stall1), 70'(vecs[i].es));
            check($sformatf("v%0d c4.stall_cnt", i), 70'(stall2), 70'(vecs[i].es));
        end

        // Long stall: 4-bit counter pins at 15, 16-bit one keeps counting, payload stays put.
        cpu_rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stop = 6'b110000;
        drive_all(1'b1, 'hC, 'h600);
        for (int i = 0; i < 20; i++) tick();
        check("sat c4.stall_cnt", 70'(stall2), 70'd15);
        check("sat stall_cnt", 70'(stall0), 70'd20);
        check("sat held.data", 70'(bus0.out_data), 70'd9);
        check("sat held.valid", 70'(bus0.out_valid), 70'd1);
        cnt_clr = 1'b1;
        tick();
        check("clr+hold c4.stall_cnt", 70'(stall2), 70'd0);
        check("clr+hold stall_cnt", 70'(stall0), 70'd0);
        cnt_clr = 1'b0; stop = 6'b010000;
        for (int i = 0; i < 17; i++) tick();
        check("sat c4.bubble_cnt", 70'(bubble2), 70'd15);
        check("sat bubble_cnt", 70'(bubble0), 70'd17);
        check("sat stall unchanged", 70'(stall0), 70'd0);

        // Wide payload, STAGE_IDX=0: only stop[1:0] matter, upper bits randomised.
        d1 = {6'h21, 64'hDEAD_BEEF_0123_4567};
        d2 = {6'h3E, 64'h0BAD_F00D_8765_4321};
        stop = 6'b000000;
        cpu_rst = 1'b1;
        bus3.in_valid = 1'b1; bus3.in_data = d1; bus3.in_pc = 32'h40;
        tick();
        check("w reset.valid", 70'(bus3.out_valid), 70'd0);
        check("w reset.data", bus3.out_data, 70'd0);
        cpu_rst = 1'b0;
        stop3 = {4'($urandom_range(0, 15)), 2'b00};
        tick();
        check("w adv.valid", 70'(bus3.out_valid), 70'd1);
        check("w adv.data", bus3.out_data, d1);
        check("w adv.pc", 70'(bus3.out_pc), 70'h40);
        bus3.in_data = d2; bus3.in_pc = 32'h44;
        for (int i = 0; i < 3; i++) begin
            stop3 = {4'($urandom_range(0, 15)), 2'b11};
            tick();
            check($sformatf("w hold%0d.data", i), bus3.out_data, d1);
        end
        check("w stall_cnt", 70'(stall3), 70'd3);
        stop3 = {4'($urandom_range(0, 15)), 2'b01};
        tick();
        check("w bubble.valid", 70'(bus3.out_valid), 70'd0);
        check("w bubble.data", bus3.out_data, 70'd0);
        check("w bubble.pc", 70'(bus3.out_pc), 70'd0);
        check("w bubble_cnt", 70'(bubble3), 70'd1);
        stop3 = {4'($urandom_range(0, 15)), 2'b10};
        tick();
        check("w dn-only adv.data", bus3.out_data, d2);
        check("w dn-only adv.pc", 70'(bus3.out_pc), 70'h44);
        check("w dn-only stall_cnt", 70'(stall3), 70'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the hand-written per-stage registers (IF/ID … MEM/WB) with one configurable block. It carries a valid bit, an opaque payload and the stage PC from stage N to stage N+1. It honours the shared `stop` stall vector with bubble/hold semantics and adds an explicit flush input. It also has a selectable bubble-clearing mode and saturating stall/bubble performance counters.

## Interface
- DATA_W, 38: payload width in bits (e.g. rfwe + rfwa + result = 1+5+32).
- PC_W, 32: stage PC width.
- STOP_W, 6: width of the shared stall vector.
- STAGE_IDX, 4: index of the upstream stage in `stop`; the downstream stage is STAGE_IDX+1. Must satisfy STAGE_IDX+1 < STOP_W; elaboration error otherwise.
- CLEAR_ON_BUBBLE, 1: 1 = bubble/flush zeroes payload and PC; 0 = only out_valid clears, payload/PC hold (low-toggle mode).
- RESET_PC, 0: PC value loaded on reset and on zeroing bubbles.
- CNT_W, 16: performance counter width.

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage holds a live instruction.
- in_data  in  DATA_W  upstream payload.
- in_pc  in  PC_W  upstream PC.
- stop  in  STOP_W  stall vector; 1 = stage stalled.
- flush  in  1  kill register contents this cycle (branch/exception).
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  register holds a live instruction.
- out_data  out  DATA_W  registered payload.
- out_pc  out  PC_W  registered PC.
- stall_cnt  out  CNT_W  cycles spent in HOLD.
- bubble_cnt  out  CNT_W  bubbles inserted (BUBBLE or FLUSH).

## Operation
- Let up = stop[STAGE_IDX], dn = stop[STAGE_IDX+1]. Each cycle selects exactly one action, in strict priority:
  1. RESET (cpu_rst=1): out_valid=0, out_data=0, out_pc=RESET_PC, stall_cnt=0, bubble_cnt=0, regardless of CLEAR_ON_BUBBLE.
  2. FLUSH (flush=1): out_valid=0. If CLEAR_ON_BUBBLE=1, out_data=0 and out_pc=RESET_PC; otherwise both hold. bubble_cnt+1. Flush overrides any stall state.
  3. BUBBLE (up=1, dn=0): out_valid=0; payload/PC handled as in FLUSH. bubble_cnt+1.
  4. HOLD (up=1, dn=1): all outputs keep their value; stall_cnt+1.
  5. ADVANCE (up=0): out_valid<=in_valid, out_data<=in_data, out_pc<=in_pc, unconditionally. dn=1 with up=0 is treated as ADVANCE; the stall controller never produces it, and the bench flags it as a protocol warning only.
- The block has no FSM beyond the registered state; the action is a pure function of the current inputs.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces both to 0 and takes priority over a simultaneous increment (result 0, not 1).
  - Reset also clears them.
  - Counters are not affected by in_valid; a bubble over an already-invalid register still counts.
- Stop bits other than up/dn are ignored.

## Timing
- Latency 1 cycle: in_* sampled at edge k appear on out_* after edge k.
- No combinational path from inputs to outputs; all outputs are registered.
- Reset mid-stream: the next edge with cpu_rst=1 discards content; the first capture is on the first edge after cpu_rst deasserts (if up=0).
- HOLD can last any number of cycles with no data loss. Release: up=1, dn=0 produces one BUBBLE; up=0 resumes ADVANCE.
- Counter values are visible the cycle after the counted event.

## Test plan
- Reset: drive cpu_rst=1 for 2 cycles with in_valid=1, in_data=0x2A, RESET_PC=0xBFC00000 -> out_valid=0, out_data=0, out_pc=0xBFC00000, both counters 0.
- Advance stream: stop=0, feed pc 0x100, 0x104, 0x108 with data 1, 2, 3 -> outputs lag by exactly 1 cycle, out_valid=1 each cycle.
- Hold then bubble: stop=6'b110000 for 3 cycles, then 6'b010000 -> payload held at its pre-stall value for 3 cycles. Then out_valid=0; data=0 with CLEAR_ON_BUBBLE=1, or data unchanged with CLEAR_ON_BUBBLE=0. stall_cnt=3, bubble_cnt=1.
- Flush vs stall: flush=1 with stop=6'b110000 -> out_valid=0, bubble_cnt+1, stall_cnt unchanged.
- Counter saturation/clear: CNT_W=4, hold 20 cycles -> stall_cnt=15. Assert cnt_clr together with another HOLD cycle -> stall_cnt=0.
- Parameter sweep: DATA_W=70, STAGE_IDX=0 -> up=stop[0] and dn=stop[1] control the stage; other stop bits toggled randomly cause no effect.
